enc_share_sched: RTL and testbench

Round-robin scheduler that shares one binary-to-one-hot encode stage between `NREQ` requesters. Each requester offers a `W`-bit binary code over a valid/ready handshake. The block grants one requester per cycle, encodes the code to a `2**W`-bit one-hot word and presents it, tagged with the requester index, on a single backpressured output port. It sits between the request sources and the encoder consumer, and replaces per-requester encoder instances.

---
 rtl/enc_share_sched_pkg.sv | 18 +
 rtl/enc_share_sched_if.sv | 36 +++
 rtl/enc_share_sched_rr_pick.sv | 34 +++
 rtl/enc_share_sched.sv | 87 ++++++++
 tb/tb_enc_share_sched.sv | 135 +++++++++++++
 5 files changed

// File: rtl/enc_share_sched_pkg.sv
// enc_pkg
//   Shared constants and helpers for the shared one-hot encode scheduler.
//   ENC_W      default binary code width
//   ENC_NREQ   default number of requesters
//   bin2onehot binary code -> 2**ENC_W-bit one-hot word
package enc_pkg;

    localparam int ENC_W    = 4;
    localparam int ENC_NREQ = 4;

    function automatic logic [2**ENC_W-1:0] bin2onehot(input logic [ENC_W-1:0] code);
        logic [2**ENC_W-1:0] onehot;
        onehot       = '0;
        onehot[code] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/enc_share_sched_if.sv
// enc_share_sched_if
//   Request and result bundle of the shared encode scheduler.
//   req_valid/req_data/req_mask/req_ready : per-requester accept handshake
//   out_valid/out_data/out_id/out_ready   : backpressured one-hot result port
//   stat_grants                           : saturating grant counter
//   modport master : the scheduler itself
//   modport slave  : the request sources and result consumer
interface enc_share_sched_if
    import enc_pkg::*;
#(
    parameter int NREQ = ENC_NREQ,
    parameter int W    = ENC_W,
    parameter int IDW  = $clog2(NREQ)
);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_mask;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic [2**W-1:0]   out_data;
    logic [IDW-1:0]    out_id;
    logic              out_ready;
    logic [15:0]       stat_grants;

    modport master (
        input  req_valid, req_data, req_mask, out_ready,
        output req_ready, out_valid, out_data, out_id, stat_grants
    );

    modport slave (
        output req_valid, req_data, req_mask, out_ready,
        input  req_ready, out_valid, out_data, out_id, stat_grants
    );

endinterface

// File: rtl/enc_share_sched_rr_pick.sv
// rr_pick
//   Combinational round-robin picker: first set bit of eligible found by
//   scanning upward from ptr with wrap.
//   eligible : candidate requesters
//   ptr      : highest-priority index for this cycle
//   gnt_idx  : chosen index (0 when gnt_any is low)
//   gnt_any  : at least one candidate present
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  gnt_idx,
    output logic            gnt_any
);

    // Scan offsets from farthest to nearest so the nearest eligible index
    // (smallest offset from ptr) is the one left standing.
    always_comb begin
        int k;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = int'(ptr) + i;
            if (k >= NREQ) k = k - NREQ;
            if (eligible[k]) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'(k);
            end
        end
    end

endmodule

// File: rtl/enc_share_sched.sv
// enc_share_sched
//   Shares one binary-to-one-hot encode stage between NREQ requesters with
//   round-robin arbitration and a single registered, backpressured output.
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : request/result bundle (enc_share_sched_if.master)
module enc_share_sched
    import enc_pkg::*;
#(
    parameter int NREQ = ENC_NREQ,
    parameter int W    = ENC_W,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    enc_share_sched_if.master      bus
);

    logic [NREQ-1:0] eligible;
    logic            take;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_any;
    logic [W-1:0]    gnt_code;
    logic [2**W-1:0] onehot;
    logic [NREQ-1:0] ready_c;

    logic [IDW-1:0]  ptr;
    logic            out_valid_q;
    logic [2**W-1:0] out_data_q;
    logic [IDW-1:0]  out_id_q;
    logic [15:0]     stat_q;

    assign eligible = bus.req_valid & bus.req_mask;
    assign take     = !out_valid_q || bus.out_ready;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .gnt_idx  (gnt_idx),
        .gnt_any  (gnt_any)
    );

    assign gnt_code = bus.req_data[int'(gnt_idx) * W +: W];

    if (W == ENC_W) begin : g_pkg_enc
        assign onehot = bin2onehot(gnt_code);
    end else begin : g_local_enc
        always_comb begin
            onehot           = '0;
            onehot[gnt_code] = 1'b1;
        end
    end

    // No accept strobe while reset is held: the register update is
    // discarded, so a handshake there would silently drop a request.
    always_comb begin
        ready_c = '0;
        if (rst && take && gnt_any) ready_c[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            stat_q      <= '0;
        end else if (take) begin
            if (gnt_any) begin
                out_valid_q <= 1'b1;
                out_data_q  <= onehot;
                out_id_q    <= gnt_idx;
                ptr         <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                if (stat_q != 16'hFFFF) stat_q <= stat_q + 16'd1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready   = ready_c;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_id      = out_id_q;
    assign bus.stat_grants = stat_q;

endmodule

// File: tb/tb_enc_share_sched.sv
// tb_enc_share_sched
//   Directed bench for enc_share_sched (NREQ=4, W=4). Inputs change 1 ns
//   after the rising edge; outputs are compared 3 ns after the rising edge.
module tb_enc_share_sched;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    enc_share_sched_if #(.NREQ(4), .W(4)) bus ();

    enc_share_sched u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance to 1 ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [15:0] d,
                           input logic [1:0] id, input logic [15:0] st);
        #2;
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, ".out_data"}, 32'(bus.out_data), 32'(d));
        chk({tag, ".out_id"}, 32'(bus.out_id), 32'(id));
        chk({tag, ".stat"}, 32'(bus.stat_grants), 32'(st));
    endtask

    task automatic chk_rdy(input string tag, input logic [3:0] r);
        #2;
        chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'(r));
    endtask

    initial begin
        // codes: req0=3, req1=7, req2=0, req3=15
        bus.req_data  = 16'hF073;
        bus.req_valid = 4'b1111;
        bus.req_mask  = 4'b1111;
        bus.out_ready = 1'b1;
        rst           = 1'b0;

        // 1. reset held for three cycles with everyone requesting
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("reset", 1'b0, 16'h0000, 2'd0, 16'd0);
            chk("reset.req_ready", 32'(bus.req_ready), 32'h0);
        end

        // 2. rotation 0,1,2,3 then back to 0
        rst = 1'b1;
        chk_rdy("rot0", 4'b0001);
        tick(); chk_out("rot0", 1'b1, 16'h0008, 2'd0, 16'd1);
        chk("rot1.req_ready", 32'(bus.req_ready), 32'h2);
        tick(); chk_out("rot1", 1'b1, 16'h0080, 2'd1, 16'd2);
        chk("rot2.req_ready", 32'(bus.req_ready), 32'h4);
        tick(); chk_out("rot2", 1'b1, 16'h0001, 2'd2, 16'd3);
        chk("rot3.req_ready", 32'(bus.req_ready), 32'h8);
        tick(); chk_out("rot3", 1'b1, 16'h8000, 2'd3, 16'd4);
        tick(); chk_out("rot4", 1'b1, 16'h0008, 2'd0, 16'd5);

        // 3. backpressure with requester 1 pending (ptr = 1)
        bus.req_valid = 4'b0010;
        bus.out_ready = 1'b0;
        chk_rdy("bp", 4'b0000);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("bp_hold", 1'b1, 16'h0008, 2'd0, 16'd5);
            chk("bp_hold.req_ready", 32'(bus.req_ready), 32'h0);
        end
        bus.out_ready = 1'b1;
        chk_rdy("bp_release", 4'b0010);
        tick(); chk_out("bp_grant", 1'b1, 16'h0080, 2'd1, 16'd6);

        // 4. mask 1001 from ptr = 2: grants 3,0,3,0
        bus.req_valid = 4'b1111;
        bus.req_mask  = 4'b1001;
        chk_rdy("mask0", 4'b1000);
        tick(); chk_out("mask0", 1'b1, 16'h8000, 2'd3, 16'd7);
        chk("mask1.req_ready", 32'(bus.req_ready), 32'h1);
        tick(); chk_out("mask1", 1'b1, 16'h0008, 2'd0, 16'd8);
        tick(); chk_out("mask2", 1'b1, 16'h8000, 2'd3, 16'd9);
        tick(); chk_out("mask3", 1'b1, 16'h0008, 2'd0, 16'd10);

        // 5. idle bubble: requester 2 alone, nothing, then requester 0 via wrap
        bus.req_mask  = 4'b1111;
        bus.req_valid = 4'b0100;
        chk_rdy("idle_req2", 4'b0100);
        tick(); chk_out("idle_req2", 1'b1, 16'h0001, 2'd2, 16'd11);
        bus.req_valid = 4'b0000;
        chk_rdy("idle_none", 4'b0000);
        tick(); chk_out("idle_bubble", 1'b0, 16'h0001, 2'd2, 16'd11);
        bus.req_valid = 4'b0001;
        chk_rdy("wrap_req0", 4'b0001);
        tick(); chk_out("wrap_req0", 1'b1, 16'h0008, 2'd0, 16'd12);

        // 6a. reset while output is valid
        rst = 1'b0;
        chk_rdy("mid_reset", 4'b0000);
        tick(); chk_out("mid_reset", 1'b0, 16'h0000, 2'd0, 16'd0);

        // 6b. saturation: continuous grants, ids cycle from 0
        rst = 1'b1;
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 65534; i++) @(posedge clk);
        #3;
        chk("sat_65534.stat", 32'(bus.stat_grants), 32'hFFFE);
        chk("sat_65534.out_id", 32'(bus.out_id), 32'd1);
        @(posedge clk); #3;
        chk("sat_65535.stat", 32'(bus.stat_grants), 32'hFFFF);
        for (int i = 0; i < 4465; i++) @(posedge clk);
        #3;
        chk("sat_70000.stat", 32'(bus.stat_grants), 32'hFFFF);
        chk("sat_70000.out_id", 32'(bus.out_id), 32'd3);
        chk("sat_70000.out_data", 32'(bus.out_data), 32'h8000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
